// File: rtl/microcode_executor.sv
// Executes one sequencer control word per accepted cycle on the 65C02 register set,
// and runs the two-cycle vector fetch that loads PC from $FFFA/$FFFC/$FFFE.
module microcode_executor #(
  parameter logic [7:0] RESET_SP  = 8'hFF,
  parameter logic [7:0] RESET_PSR = 8'h34
) (
  input  logic        fclk,
  input  logic        resb,
  input  logic        cw_valid,
  output logic        cw_ready,
  input  logic [3:0]  signal_set,
  input  logic [7:0]  data_bus_set,
  input  logic [5:0]  address_bus_set,
  input  logic [15:0] load_store_execute,
  input  logic [9:0]  inc_dec_clr,
  input  logic [7:0]  status_flags,
  input  logic [4:0]  vector_operations,
  input  logic [7:0]  alu_result,
  input  logic [7:0]  alu_flags,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic [15:0] addr,
  output logic        rwb,
  output logic        sync,
  output logic        vpb,
  output logic        mlb,
  output logic [7:0]  reg_a,
  output logic [7:0]  reg_x,
  output logic [7:0]  reg_y,
  output logic [7:0]  reg_sp,
  output logic [7:0]  reg_psr,
  output logic [7:0]  reg_ir,
  output logic [15:0] reg_pc
);

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 16;

  localparam logic [3:0] R_Y     = 4'h0;
  localparam logic [3:0] R_X     = 4'h1;
  localparam logic [3:0] R_SP    = 4'h2;
  localparam logic [3:0] R_ALU   = 4'h3;
  localparam logic [3:0] R_A     = 4'h4;
  localparam logic [3:0] R_PCL   = 4'h5;
  localparam logic [3:0] R_PCH   = 4'h6;
  localparam logic [3:0] R_IDL   = 4'h7;
  localparam logic [3:0] R_DBUFF = 4'h8;
  localparam logic [3:0] R_PSR   = 4'h9;

  localparam logic [DW-1:0] PSR_BIT5 = 8'h20;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VEC_LO = 2'd1,
    VEC_HI = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] a_q, a_d, x_q, x_d, y_q, y_d, sp_q, sp_d;
  logic [DW-1:0] psr_q, psr_d, ir_q, ir_d, idl_q, idl_d, dbuff_q, dbuff_d;
  logic [AW-1:0] pc_q, pc_d, vec_q, vec_d;

  logic [DW-1:0] bus_c;
  logic [DW-1:0] addr_hi_c, addr_lo_c;
  logic          accept_c;
  logic [3:0]    dst_c;
  logic [AW-1:0] vec_sel_c;
  logic          unused_c;

  // Mixed inc/dec helper: simultaneous inc and dec leaves the value alone
  function automatic logic [DW-1:0] step8(input logic [DW-1:0] v, input logic inc,
                                          input logic dec);
    logic [DW-1:0] r;
    r = v;
    if (inc && !dec) r = DW'(v + 8'd1);
    if (dec && !inc) r = DW'(v - 8'd1);
    return r;
  endfunction

  assign cw_ready = (state_q == IDLE);
  assign accept_c = cw_valid && cw_ready;
  assign dst_c    = data_bus_set[3:0];

  assign unused_c = ^{load_store_execute[15], load_store_execute[13:6],
                      load_store_execute[4], load_store_execute[1:0]};

  // Internal bus source mux
  always_comb begin
    bus_c = '0;
    case (data_bus_set[7:4])
      R_Y:     bus_c = y_q;
      R_X:     bus_c = x_q;
      R_SP:    bus_c = sp_q;
      R_ALU:   bus_c = alu_result;
      R_A:     bus_c = a_q;
      R_PCL:   bus_c = pc_q[7:0];
      R_PCH:   bus_c = pc_q[15:8];
      R_IDL:   bus_c = idl_q;
      R_DBUFF: bus_c = dbuff_q;
      R_PSR:   bus_c = psr_q | PSR_BIT5;
      default: bus_c = '0;
    endcase
  end

  always_comb begin
    addr_hi_c = '0;
    addr_lo_c = '0;
    case (address_bus_set[5:3])
      3'b010:  addr_hi_c = 8'h01;
      3'b110:  addr_hi_c = idl_q;
      3'b101:  addr_hi_c = pc_q[15:8];
      default: addr_hi_c = '0;
    endcase
    case (address_bus_set[2:0])
      3'b010:  addr_lo_c = sp_q;
      3'b110:  addr_lo_c = idl_q;
      3'b101:  addr_lo_c = pc_q[7:0];
      3'b000:  addr_lo_c = y_q;
      3'b001:  addr_lo_c = x_q;
      3'b011:  addr_lo_c = alu_result;
      default: addr_lo_c = '0;
    endcase
  end

  always_comb begin
    vec_sel_c = 16'hFFFE;
    if (vector_operations[3])      vec_sel_c = 16'hFFFC;
    else if (vector_operations[2]) vec_sel_c = 16'hFFFA;
  end

  // External strobes and buses; reset forces the quiescent values
  always_comb begin
    addr = pc_q;
    rwb  = 1'b1;
    sync = 1'b0;
    vpb  = 1'b1;
    mlb  = 1'b1;
    dout = '0;
    if (resb) begin
      case (state_q)
        IDLE: begin
          if (cw_valid) begin
            addr = {addr_hi_c, addr_lo_c};
            rwb  = signal_set[0];
            sync = signal_set[2];
            mlb  = ~signal_set[1];
            vpb  = ~signal_set[3];
            dout = bus_c;
          end
        end
        VEC_LO: begin
          addr = vec_q;
          vpb  = 1'b0;
        end
        VEC_HI: begin
          addr = AW'(vec_q + 16'd1);
          vpb  = 1'b0;
        end
        default: addr = pc_q;
      endcase
    end
  end

  // Next-state: word execution in IDLE, PC byte loads during the vector fetch
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    x_d     = x_q;
    y_d     = y_q;
    sp_d    = sp_q;
    psr_d   = psr_q;
    ir_d    = ir_q;
    idl_d   = idl_q;
    dbuff_d = dbuff_q;
    pc_d    = pc_q;
    vec_d   = vec_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          if (dst_c == R_A)               a_d = bus_c;
          else if (load_store_execute[2]) a_d = alu_result;
          else                            a_d = step8(a_q, inc_dec_clr[8], inc_dec_clr[7]);

          x_d  = (dst_c == R_X)  ? bus_c : step8(x_q,  inc_dec_clr[6], inc_dec_clr[5]);
          y_d  = (dst_c == R_Y)  ? bus_c : step8(y_q,  inc_dec_clr[4], inc_dec_clr[3]);
          sp_d = (dst_c == R_SP) ? bus_c : step8(sp_q, inc_dec_clr[2], inc_dec_clr[1]);

          if (inc_dec_clr[0])      idl_d = '0;
          else if (dst_c == R_IDL) idl_d = bus_c;

          if (dst_c == R_DBUFF)           dbuff_d = bus_c;
          else if (load_store_execute[5]) dbuff_d = din;

          if (load_store_execute[14]) ir_d = din;

          // A bus write to either PC byte suppresses the increment entirely
          if (dst_c == R_PCL)      pc_d[7:0]  = bus_c;
          else if (dst_c == R_PCH) pc_d[15:8] = bus_c;
          else if (inc_dec_clr[9]) pc_d       = AW'(pc_q + 16'd1);

          if (dst_c == R_PSR)             psr_d = bus_c;
          else if (load_store_execute[3]) psr_d = (psr_q & ~status_flags) | (alu_flags & status_flags);
          if (vector_operations[0]) begin
            psr_d[2] = 1'b1;
            psr_d[3] = 1'b0;
          end
          psr_d = psr_d | PSR_BIT5;

          if (vector_operations[4]) begin
            state_d = VEC_LO;
            vec_d   = vec_sel_c;
          end
        end
      end
      VEC_LO: begin
        pc_d[7:0] = din;
        state_d   = VEC_HI;
      end
      VEC_HI: begin
        pc_d[15:8] = din;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge fclk or negedge resb) begin
    if (!resb) begin
      state_q <= IDLE;
      a_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      sp_q    <= RESET_SP;
      psr_q   <= RESET_PSR | PSR_BIT5;
      ir_q    <= '0;
      idl_q   <= '0;
      dbuff_q <= '0;
      pc_q    <= '0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sp_q    <= sp_d;
      psr_q   <= psr_d;
      ir_q    <= ir_d;
      idl_q   <= idl_d;
      dbuff_q <= dbuff_d;
      pc_q    <= pc_d;
      vec_q   <= vec_d;
    end
  end

  assign reg_a   = a_q;
  assign reg_x   = x_q;
  assign reg_y   = y_q;
  assign reg_sp  = sp_q;
  assign reg_psr = psr_q | PSR_BIT5;
  assign reg_ir  = ir_q;
  assign reg_pc  = pc_q;

endmodule

// File: tb/tb_microcode_executor.sv
// Directed bench for microcode_executor: stimulus pushes time-stamped expectations,
// a negedge monitor pops and compares them in the cycle they fall due.
module tb_microcode_executor;

  logic        fclk = 1'b0;
  logic        resb;
  logic        cw_valid, cw_ready;
  logic [3:0]  signal_set;
  logic [7:0]  data_bus_set;
  logic [5:0]  address_bus_set;
  logic [15:0] load_store_execute;
  logic [9:0]  inc_dec_clr;
  logic [7:0]  status_flags;
  logic [4:0]  vector_operations;
  logic [7:0]  alu_result, alu_flags, din, dout;
  logic [15:0] addr;
  logic        rwb, sync, vpb, mlb;
  logic [7:0]  reg_a, reg_x, reg_y, reg_sp, reg_psr, reg_ir;
  logic [15:0] reg_pc;

  microcode_executor dut (
    .fclk(fclk), .resb(resb), .cw_valid(cw_valid), .cw_ready(cw_ready),
    .signal_set(signal_set), .data_bus_set(data_bus_set),
    .address_bus_set(address_bus_set), .load_store_execute(load_store_execute),
    .inc_dec_clr(inc_dec_clr), .status_flags(status_flags),
    .vector_operations(vector_operations), .alu_result(alu_result),
    .alu_flags(alu_flags), .din(din), .dout(dout), .addr(addr),
    .rwb(rwb), .sync(sync), .vpb(vpb), .mlb(mlb),
    .reg_a(reg_a), .reg_x(reg_x), .reg_y(reg_y), .reg_sp(reg_sp),
    .reg_psr(reg_psr), .reg_ir(reg_ir), .reg_pc(reg_pc)
  );

  always #5 fclk = ~fclk;

  localparam int S_A = 0, S_X = 1, S_SP = 2, S_PSR = 3, S_PC = 4, S_ADDR = 5,
                 S_DOUT = 6, S_RDY = 7, S_RWB = 8, S_SYNC = 9, S_VPB = 10,
                 S_MLB = 11, S_IR = 12;

  typedef struct {
    string       name;
    int          sel;
    int          due;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge fclk) cyc <= cyc + 1;

  function automatic logic [15:0] observe(input int sel);
    case (sel)
      S_A:    return {8'h00, reg_a};
      S_X:    return {8'h00, reg_x};
      S_SP:   return {8'h00, reg_sp};
      S_PSR:  return {8'h00, reg_psr};
      S_PC:   return reg_pc;
      S_ADDR: return addr;
      S_DOUT: return {8'h00, dout};
      S_RDY:  return {15'h0, cw_ready};
      S_RWB:  return {15'h0, rwb};
      S_SYNC: return {15'h0, sync};
      S_VPB:  return {15'h0, vpb};
      S_MLB:  return {15'h0, mlb};
      S_IR:   return {8'h00, reg_ir};
      default: return 16'hDEAD;
    endcase
  endfunction

  task automatic expect_at(input string name, input int sel, input int due,
                           input logic [15:0] exp);
    exp_t e;
    e.name = name; e.sel = sel; e.due = due; e.exp = exp;
    sb.push_back(e);
  endtask

  // Monitor: compare every expectation due in this cycle, flag any that were missed
  initial begin
    forever begin
      @(negedge fclk);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due == cyc) begin
          total++;
          if (observe(sb[i].sel) !== sb[i].exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", sb[i].name, cyc,
                     observe(sb[i].sel), sb[i].exp);
          end
          sb.delete(i);
        end else if (sb[i].due < cyc) begin
          total++;
          bad++;
          $display("FAIL %s missed due=%0d", sb[i].name, sb[i].due);
          sb.delete(i);
        end
      end
    end
  end

  task automatic step();
    @(posedge fclk);
    #1;
  endtask

  task automatic clr();
    cw_valid           = 1'b1;
    signal_set         = 4'b0001;
    data_bus_set       = 8'hAA;
    address_bus_set    = 6'b111111;
    load_store_execute = '0;
    inc_dec_clr        = '0;
    status_flags       = '0;
    vector_operations  = '0;
    alu_result         = '0;
    alu_flags          = '0;
  endtask

  task automatic idle();
    clr();
    cw_valid = 1'b0;
  endtask

  initial begin
    resb = 1'b0;
    din  = 8'h00;
    idle();
    step();
    expect_at("rst_pc",   S_PC,   cyc, 16'h0000);
    expect_at("rst_sp",   S_SP,   cyc, 16'h00FF);
    expect_at("rst_psr",  S_PSR,  cyc, 16'h0034);
    expect_at("rst_rdy",  S_RDY,  cyc, 16'h0001);
    expect_at("rst_vpb",  S_VPB,  cyc, 16'h0001);
    expect_at("rst_rwb",  S_RWB,  cyc, 16'h0001);
    expect_at("rst_sync", S_SYNC, cyc, 16'h0000);
    expect_at("rst_mlb",  S_MLB,  cyc, 16'h0001);
    expect_at("rst_addr", S_ADDR, cyc, 16'h0000);
    expect_at("rst_a",    S_A,    cyc, 16'h0000);
    step(); resb = 1'b1;

    // Register transfers over the internal bus
    step(); clr(); data_bus_set = 8'h34; alu_result = 8'h5A;
    expect_at("alu_to_a", S_A, cyc + 1, 16'h005A);
    step(); clr(); data_bus_set = 8'h41;
    expect_at("a_to_x_dout", S_DOUT, cyc, 16'h005A);
    expect_at("a_to_x", S_X, cyc + 1, 16'h005A);
    step(); clr(); data_bus_set = 8'h3B; alu_result = 8'h77;
    expect_at("alu_none_dout", S_DOUT, cyc, 16'h0077);
    expect_at("alu_none_a", S_A, cyc + 1, 16'h005A);
    expect_at("alu_none_x", S_X, cyc + 1, 16'h005A);

    // Wrap and inc/dec conflict
    step(); clr(); data_bus_set = 8'h31; alu_result = 8'h7F;
    expect_at("x_load", S_X, cyc + 1, 16'h007F);
    step(); clr(); inc_dec_clr = 10'h060;
    expect_at("x_incdec", S_X, cyc + 1, 16'h007F);
    step(); clr(); data_bus_set = 8'h32; alu_result = 8'h00;
    expect_at("sp_load", S_SP, cyc + 1, 16'h0000);
    step(); clr(); inc_dec_clr = 10'h002;
    expect_at("sp_wrap", S_SP, cyc + 1, 16'h00FF);
    step(); clr(); data_bus_set = 8'h36; alu_result = 8'hFF;
    step(); clr(); data_bus_set = 8'h35; alu_result = 8'hFF;
    expect_at("pc_ffff", S_PC, cyc + 1, 16'hFFFF);
    step(); clr(); inc_dec_clr = 10'h200;
    expect_at("pc_wrap", S_PC, cyc + 1, 16'h0000);

    // Address composition and strobes
    step(); clr(); data_bus_set = 8'h36; alu_result = 8'h12;
    step(); clr(); data_bus_set = 8'h35; alu_result = 8'h34;
    step(); clr(); address_bus_set = 6'b101101; signal_set = 4'b1110;
    expect_at("addr_pc",  S_ADDR, cyc, 16'h1234);
    expect_at("str_rwb",  S_RWB,  cyc, 16'h0000);
    expect_at("str_sync", S_SYNC, cyc, 16'h0001);
    expect_at("str_mlb",  S_MLB,  cyc, 16'h0000);
    expect_at("str_vpb",  S_VPB,  cyc, 16'h0000);
    step(); clr(); data_bus_set = 8'h32; alu_result = 8'hF0;
    step(); clr(); address_bus_set = 6'b010010;
    expect_at("addr_stack", S_ADDR, cyc, 16'h01F0);
    step(); clr(); data_bus_set = 8'h37; alu_result = 8'h55;
    step(); clr(); address_bus_set = 6'b110110; data_bus_set = 8'h37;
    alu_result = 8'h66; inc_dec_clr = 10'h001;
    expect_at("addr_idl", S_ADDR, cyc, 16'h5555);
    step(); clr(); address_bus_set = 6'b110110;
    expect_at("idl_clr_wins", S_ADDR, cyc, 16'h0000);
    step(); clr(); address_bus_set = 6'b010011; alu_result = 8'h9C;
    expect_at("addr_alu_lo", S_ADDR, cyc, 16'h019C);

    // Status update under mask, bus write to PSR keeps bit5
    step(); clr(); load_store_execute = 16'h0008; status_flags = 8'h83; alu_flags = 8'hFF;
    expect_at("psr_upd", S_PSR, cyc + 1, 16'h00B7);
    step(); clr(); status_flags = 8'h83; alu_flags = 8'h00;
    expect_at("psr_hold", S_PSR, cyc + 1, 16'h00B7);
    step(); clr(); data_bus_set = 8'h39; alu_result = 8'h08;
    expect_at("psr_bus", S_PSR, cyc + 1, 16'h0028);
    step(); clr(); alu_result = 8'h10; load_store_execute = 16'h0004; inc_dec_clr = 10'h100;
    expect_at("mov_beats_inc", S_A, cyc + 1, 16'h0010);

    // Reset vector fetch; the word held during the fetch must not execute
    step(); clr(); vector_operations = 5'b11001;
    expect_at("vec_psr", S_PSR, cyc + 1, 16'h0024);
    step(); clr(); data_bus_set = 8'h34; alu_result = 8'hEE; din = 8'h34;
    expect_at("vlo_rdy",  S_RDY,  cyc, 16'h0000);
    expect_at("vlo_addr", S_ADDR, cyc, 16'hFFFC);
    expect_at("vlo_vpb",  S_VPB,  cyc, 16'h0000);
    expect_at("vlo_rwb",  S_RWB,  cyc, 16'h0001);
    step(); din = 8'h12;
    expect_at("vhi_addr", S_ADDR, cyc, 16'hFFFD);
    expect_at("vhi_vpb",  S_VPB,  cyc, 16'h0000);
    expect_at("vhi_rdy",  S_RDY,  cyc, 16'h0000);
    step(); idle(); din = 8'hA9;
    expect_at("vdone_rdy",  S_RDY,  cyc, 16'h0001);
    expect_at("vdone_pc",   S_PC,   cyc, 16'h1234);
    expect_at("vdone_a",    S_A,    cyc, 16'h0010);
    expect_at("vdone_vpb",  S_VPB,  cyc, 16'h0001);
    expect_at("vdone_addr", S_ADDR, cyc, 16'h1234);
    step(); clr(); load_store_execute = 16'h4000;
    expect_at("ir_load", S_IR, cyc + 1, 16'h00A9);

    // IRQ vector, then reset asserted during VEC_HI
    step(); clr(); vector_operations = 5'b10010;
    step(); idle();
    expect_at("irq_lo_addr", S_ADDR, cyc, 16'hFFFE);
    step();
    expect_at("irq_hi_addr", S_ADDR, cyc, 16'hFFFF);
    @(negedge fclk); #1; resb = 1'b0;
    expect_at("abort_pc",   S_PC,   cyc + 1, 16'h0000);
    expect_at("abort_sp",   S_SP,   cyc + 1, 16'h00FF);
    expect_at("abort_psr",  S_PSR,  cyc + 1, 16'h0034);
    expect_at("abort_rdy",  S_RDY,  cyc + 1, 16'h0001);
    expect_at("abort_vpb",  S_VPB,  cyc + 1, 16'h0001);
    expect_at("abort_addr", S_ADDR, cyc + 1, 16'h0000);
    expect_at("abort_ir",   S_IR,   cyc + 1, 16'h0000);
    step(); step(); resb = 1'b1;
    step(); step(); step();

    foreach (sb[i]) begin
      total++;
      bad++;
      $display("FAIL %s never checked due=%0d", sb[i].name, sb[i].due);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
